// File: rtl/rb_pkg.sv
// rb_pkg: shared defaults and width helpers for the readback concentrator.
package rb_pkg;

    localparam int unsigned RB_N_CH = 6;
    localparam int unsigned RB_DW   = 28;

    function automatic int unsigned rb_clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Channel-index width; at least one bit even for degenerate channel counts.
    function automatic int unsigned rb_id_w(input int unsigned n_ch);
        return (n_ch < 2) ? 1 : rb_clog2(n_ch);
    endfunction

    localparam int unsigned RB_ID_W = rb_id_w(RB_N_CH);

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker. The search begins one slot past i_ptr
// and wraps from N-1 back to 0; the first requester found wins.
module rr_pick #(
    parameter int unsigned N    = 6,
    parameter int unsigned ID_W = 3
) (
    input  logic [N-1:0]    i_req,
    input  logic [ID_W-1:0] i_ptr,
    output logic [N-1:0]    o_gnt,
    output logic [ID_W-1:0] o_idx,
    output logic            o_any
);

    localparam int NI = int'(N);

    int w_start;
    int w_dist;
    int w_best;
    int w_sel;

    always_comb begin
        w_start = int'(i_ptr) % NI;
        w_dist  = 0;
        w_best  = NI;
        w_sel   = 0;
        o_gnt   = '0;
        for (int i = 0; i < NI; i++) begin
            // Distance of slot i from the first slot after the pointer.
            w_dist = (i + NI - 1 - w_start) % NI;
            if (i_req[i] && (w_dist < w_best)) begin
                w_best = w_dist;
                w_sel  = i;
            end
        end
        o_any = (i_req != '0);
        o_idx = ID_W'(w_sel);
        for (int i = 0; i < NI; i++) begin
            o_gnt[i] = o_any && (w_sel == i);
        end
    end

endmodule

// File: rtl/rb_concentrator.sv
// rb_concentrator: per-channel holding registers feeding one registered output via
// round-robin arbitration. Define RB_URGENT_EN to give URGENT_MASK channels strict priority.
module rb_concentrator
    import rb_pkg::*;
#(
    parameter int unsigned     N_CH        = RB_N_CH,
    parameter int unsigned     DW          = RB_DW,
    parameter int unsigned     ID_W        = rb_id_w(N_CH),
    parameter logic [N_CH-1:0] URGENT_MASK = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_CH-1:0]      in_stb,
    input  logic [N_CH*DW-1:0]   in_data,
    output logic [N_CH-1:0]      in_busy,
    output logic                 out_stb,
    output logic [DW-1:0]        out_data,
    output logic [ID_W-1:0]      out_id,
    output logic                 out_urgent,
    input  logic                 out_rdy,
    output logic [N_CH-1:0]      ovf,
    input  logic [N_CH-1:0]      ovf_clr
);

    logic [N_CH-1:0] r_valid;
    logic [DW-1:0]   r_hold [N_CH];
    logic [N_CH-1:0] r_ovf;
    logic            r_out_stb;
    logic [DW-1:0]   r_out_data;
    logic [ID_W-1:0] r_out_id;
    logic            r_out_urgent;
    logic [ID_W-1:0] r_ptr;

    logic            w_load;
    logic            w_grant;
    logic            w_any;
    logic            w_sel_urgent;
    logic [N_CH-1:0] w_gnt;
    logic [N_CH-1:0] w_drain;
    logic [N_CH-1:0] w_drop;
    logic [ID_W-1:0] w_idx;
    logic [DW-1:0]   w_sel_data;

`ifdef RB_URGENT_EN
    logic [N_CH-1:0] w_req_u;
    logic [N_CH-1:0] w_req_n;
    logic [N_CH-1:0] w_gnt_u;
    logic [N_CH-1:0] w_gnt_n;
    logic [ID_W-1:0] w_idx_u;
    logic [ID_W-1:0] w_idx_n;
    logic            w_any_u;
    logic            w_any_n;

    assign w_req_u = r_valid & URGENT_MASK;
    assign w_req_n = r_valid & ~URGENT_MASK;

    rr_pick #(
        .N    (N_CH),
        .ID_W (ID_W)
    ) u_pick_urgent (
        .i_req (w_req_u),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt_u),
        .o_idx (w_idx_u),
        .o_any (w_any_u)
    );

    rr_pick #(
        .N    (N_CH),
        .ID_W (ID_W)
    ) u_pick_normal (
        .i_req (w_req_n),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt_n),
        .o_idx (w_idx_n),
        .o_any (w_any_n)
    );

    // Both classes share one pointer; any pending urgent word pre-empts the normal class.
    assign w_gnt        = w_any_u ? w_gnt_u : w_gnt_n;
    assign w_idx        = w_any_u ? w_idx_u : w_idx_n;
    assign w_any        = w_any_u | w_any_n;
    assign w_sel_urgent = w_any_u;
`else
    logic w_unused_mask;

    assign w_unused_mask = ^URGENT_MASK;

    rr_pick #(
        .N    (N_CH),
        .ID_W (ID_W)
    ) u_pick (
        .i_req (r_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    assign w_sel_urgent = 1'b0;
`endif

    assign w_load  = ~r_out_stb | out_rdy;
    assign w_grant = w_load & w_any;
    assign w_drain = w_gnt & {N_CH{w_grant}};
    // A strobe into an occupied register is lost unless that register empties this cycle.
    assign w_drop  = in_stb & r_valid & ~w_drain;

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            if (w_gnt[i]) begin
                w_sel_data = w_sel_data | r_hold[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int i = 0; i < int'(N_CH); i++) begin
                r_hold[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(N_CH); i++) begin
                if (in_stb[i] && (!r_valid[i] || w_drain[i])) begin
                    r_valid[i] <= 1'b1;
                    r_hold[i]  <= in_data[i*DW +: DW];
                end else if (w_drain[i]) begin
                    r_valid[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= '0;
        end else begin
            r_ovf <= (r_ovf & ~ovf_clr) | w_drop;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_stb    <= 1'b0;
            r_out_data   <= '0;
            r_out_id     <= '0;
            r_out_urgent <= 1'b0;
            r_ptr        <= ID_W'(N_CH - 1);
        end else if (w_load) begin
            r_out_stb <= w_any;
            if (w_any) begin
                r_out_data   <= w_sel_data;
                r_out_id     <= w_idx;
                r_out_urgent <= w_sel_urgent;
                r_ptr        <= w_idx;
            end
        end
    end

    assign in_busy    = r_valid;
    assign ovf        = r_ovf;
    assign out_stb    = r_out_stb;
    assign out_data   = r_out_data;
    assign out_id     = r_out_id;
    assign out_urgent = r_out_urgent;

endmodule
